// File: rtl/pc_ir_unit_pkg.sv
// Shared types for the VeriRISC PC/IR stage: opcode encoding, phase type
// and phase landmarks used by the fetch/execute split.
package pc_ir_unit_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef logic [2:0] phase_t;

  localparam phase_t PHASE_FETCH_LAST = 3'd3;
  localparam phase_t PHASE_LAST       = 3'd7;

  function automatic opcode_t decode_opcode(input logic [OPC_W-1:0] bits);
    return opcode_t'(bits);
  endfunction

endpackage

// File: rtl/pc_ir_unit_if.sv
// Bus between the PC/IR stage (slave) and the sequencer/memory side (master).
interface pc_ir_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0]       data_in;
  logic                    load_ir;
  logic                    inc_pc;
  logic                    load_pc;
  logic                    halt;
  logic                    resume;
  pc_ir_unit_pkg::opcode_t opcode;
  logic [ADDR_W-1:0]       ir_addr;
  logic [ADDR_W-1:0]       addr;
  logic [ADDR_W-1:0]       pc;
  pc_ir_unit_pkg::phase_t  phase;
  logic                    fetch;
  logic                    halted;

  modport master (
    output data_in, load_ir, inc_pc, load_pc, halt, resume,
    input  opcode, ir_addr, addr, pc, phase, fetch, halted
  );

  modport slave (
    input  data_in, load_ir, inc_pc, load_pc, halt, resume,
    output opcode, ir_addr, addr, pc, phase, fetch, halted
  );

endinterface

// File: rtl/pc_ir_unit_pc_counter.sv
// Program counter: load beats increment, hold freezes everything, wraps modulo 2^ADDR_W.
module pc_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;

  // next PC selection
  always_comb begin
    pc_next_s = pc_r;
    if (hold) begin
      pc_next_s = pc_r;
    end else if (load) begin
      pc_next_s = load_val;
    end else if (inc) begin
      pc_next_s = pc_r + PC_ONE;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= '0;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/pc_ir_unit.sv
// PC/IR stage: holds PC and IR, decodes IR, muxes the memory address and
// runs a free-running 8-phase counter plus the halt/resume latch.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  pc_ir_unit_if.slave  bus
);

  logic [DATA_W-1:0] ir_r;
  logic [DATA_W-1:0] ir_next_s;
  phase_t            phase_r;
  logic              halted_r;
  logic              halted_next_s;
  logic              resume_pend_r;
  logic              resume_pend_next_s;
  logic [ADDR_W-1:0] pc_s;
  logic [ADDR_W-1:0] ir_addr_s;
  logic              fetch_s;

  assign ir_addr_s = ir_r[ADDR_W-1:0];

  pc_counter #(.ADDR_W(ADDR_W)) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .hold     (halted_r),
    .load     (bus.load_pc),
    .inc      (bus.inc_pc),
    .load_val (ir_addr_s),
    .pc       (pc_s)
  );

  // IR next value, frozen while halted
  always_comb begin
    ir_next_s = ir_r;
    if (bus.load_ir && !halted_r) begin
      ir_next_s = bus.data_in;
    end else begin
      ir_next_s = ir_r;
    end
  end

  // Halt latch: halt dominates; a resume seen while halted releases on the 7->0 edge,
  // so the unit always restarts at the top of a fetch.
  always_comb begin
    halted_next_s      = halted_r;
    resume_pend_next_s = resume_pend_r;
    if (bus.halt) begin
      halted_next_s      = 1'b1;
      resume_pend_next_s = 1'b0;
    end else if (halted_r && (phase_r == PHASE_LAST) && (resume_pend_r || bus.resume)) begin
      halted_next_s      = 1'b0;
      resume_pend_next_s = 1'b0;
    end else if (halted_r && bus.resume) begin
      resume_pend_next_s = 1'b1;
    end else begin
      halted_next_s      = halted_r;
      resume_pend_next_s = resume_pend_r;
    end
  end

  // State registers; the phase counter never stops so it tracks the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_r          <= '0;
      phase_r       <= 3'd0;
      halted_r      <= 1'b0;
      resume_pend_r <= 1'b0;
    end else begin
      ir_r          <= ir_next_s;
      phase_r       <= phase_r + 3'd1;
      halted_r      <= halted_next_s;
      resume_pend_r <= resume_pend_next_s;
    end
  end

  assign fetch_s     = (phase_r <= PHASE_FETCH_LAST);
  assign bus.fetch   = fetch_s;
  assign bus.addr    = fetch_s ? pc_s : ir_addr_s;
  assign bus.pc      = pc_s;
  assign bus.ir_addr = ir_addr_s;
  assign bus.opcode  = decode_opcode(ir_r[DATA_W-1 -: OPC_W]);
  assign bus.phase   = phase_r;
  assign bus.halted  = halted_r;

endmodule
